vote_tally: RTL and testbench

//  Downstream of the per-candidate button debouncers. Consumes their one-cycle vote pulses and keeps
//  one saturating tally per candidate. Enforces a post-vote lockout and rejects simultaneous presses.
//  In result mode it presents the tally of a selected candidate to the display logic.

---
 rtl/vote_pkg.sv | 33 +++
 rtl/vote_tally_if.sv | 47 ++++
 rtl/vote_counter.sv | 23 ++
 rtl/vote_tally.sv | 130 +++++++++++++
 tb/tb_vote_tally.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/vote_pkg.sv
// rtl/vote_pkg.sv - shared types, defaults and pulse-count helper for vote_tally
// Purpose: FSM state enum, popcount classification of the vote pulse vector,
//          default sizing constants.
// Ports:   none (package).
package vote_pkg;

  localparam int NUM_CAND_DEF = 4;
  localparam int CNT_W_DEF    = 8;

  typedef enum logic {
    IDLE,
    LOCKOUT
  } state_t;

  typedef enum logic [1:0] {
    PC_NONE,
    PC_ONE,
    PC_MANY
  } popcnt_t;

  // Classifies a pulse vector (zero-extended to 32 bits) as none/one/many.
  function automatic popcnt_t onehot_count(input logic [31:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      n += int'(v[i]);
    end
    if (n == 0)      return PC_NONE;
    else if (n == 1) return PC_ONE;
    else             return PC_MANY;
  endfunction

endpackage

// File: rtl/vote_tally_if.sv
// rtl/vote_tally_if.sv - vote/result signal bundle between host logic and vote_tally
// Purpose: groups the voting inputs and tally/result outputs.
// Ports (signals):
//   mode, vote_pulse[NUM_CAND], sel[$clog2(NUM_CAND)]  -> tally block
//   ack, collision, busy, result[CNT_W], result_valid  <- tally block
//   total[CNT_W+$clog2(NUM_CAND)]                      <- tally block (TALLY_TOTAL_EN only)
// Modports: master (drives votes/selection), slave (the tally block).
interface vote_tally_if
  import vote_pkg::*;
#(
  parameter int NUM_CAND = NUM_CAND_DEF,
  parameter int CNT_W    = CNT_W_DEF
);
  localparam int SEL_W = $clog2(NUM_CAND);
  localparam int TOT_W = CNT_W + $clog2(NUM_CAND);

  logic                mode;
  logic [NUM_CAND-1:0] vote_pulse;
  logic [SEL_W-1:0]    sel;
  logic                ack;
  logic                collision;
  logic                busy;
  logic [CNT_W-1:0]    result;
  logic                result_valid;
`ifdef TALLY_TOTAL_EN
  logic [TOT_W-1:0]    total;

  modport master (
    output mode, vote_pulse, sel,
    input  ack, collision, busy, result, result_valid, total
  );
  modport slave (
    input  mode, vote_pulse, sel,
    output ack, collision, busy, result, result_valid, total
  );
`else
  modport master (
    output mode, vote_pulse, sel,
    input  ack, collision, busy, result, result_valid
  );
  modport slave (
    input  mode, vote_pulse, sel,
    output ack, collision, busy, result, result_valid
  );
`endif

endinterface

// File: rtl/vote_counter.sv
// rtl/vote_counter.sv - saturating per-candidate tally counter
// Purpose: counts inc pulses, holding at all-ones.
// Ports: clk, rst (sync, active-high), inc (count enable), cnt[CNT_W] (tally).
module vote_counter
  import vote_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/vote_tally.sv
// rtl/vote_tally.sv - saturating vote tally with lockout, collision reject and result mux
// Purpose: accepts single one-cycle vote pulses while idle in voting mode, locks out
//          further votes for LOCK_CYCLES cycles, flags simultaneous presses, and shows
//          the selected candidate's tally in result mode.
// Ports: clk, rst (sync, active-high); bus (vote_tally_if.slave): mode, vote_pulse, sel
//        in; ack, collision, busy, result, result_valid (and total) out.
// Config: TALLY_TOTAL_EN adds a saturating count of all accepted votes on bus.total.
module vote_tally
  import vote_pkg::*;
#(
  parameter int NUM_CAND    = NUM_CAND_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int LOCK_CYCLES = 8
) (
  input  logic         clk,
  input  logic         rst,
  vote_tally_if.slave  bus
);

  localparam int LCW = (LOCK_CYCLES < 2) ? 1 : $clog2(LOCK_CYCLES + 1);

  state_t              state, state_next;
  logic [LCW-1:0]      lock_cnt, lock_next;
  logic                accept, coll;
  popcnt_t             pc;
  logic [NUM_CAND-1:0] inc_vec;
  logic [CNT_W-1:0]    tally [NUM_CAND];
  logic                ack_q, coll_q;
  logic [CNT_W-1:0]    result_q;
  logic                result_valid_q;

  assign pc = onehot_count(32'(bus.vote_pulse));

  always_comb begin
    state_next = state;
    lock_next  = lock_cnt;
    accept     = 1'b0;
    coll       = 1'b0;
    case (state)
      IDLE: begin
        if (!bus.mode) begin
          if (pc == PC_ONE) begin
            accept = 1'b1;
            if (LOCK_CYCLES != 0) begin
              state_next = LOCKOUT;
              lock_next  = LCW'(LOCK_CYCLES);
            end
          end else if (pc == PC_MANY) begin
            coll = 1'b1;
          end
        end
      end
      LOCKOUT: begin
        // Leaving on the count-of-1 cycle keeps busy high for exactly LOCK_CYCLES cycles.
        if (lock_cnt <= LCW'(1)) begin
          state_next = IDLE;
          lock_next  = '0;
        end else begin
          lock_next  = lock_cnt - 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        lock_next  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      lock_cnt <= '0;
      ack_q    <= 1'b0;
      coll_q   <= 1'b0;
    end else begin
      state    <= state_next;
      lock_cnt <= lock_next;
      ack_q    <= accept;
      coll_q   <= coll;
    end
  end

  // Only one bit can be set when accept is high, so the pulse vector is the inc vector.
  assign inc_vec = accept ? bus.vote_pulse : '0;

  for (genvar i = 0; i < NUM_CAND; i++) begin : g_cnt
    vote_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk (clk),
      .rst (rst),
      .inc (inc_vec[i]),
      .cnt (tally[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else begin
      result_valid_q <= bus.mode;
      if (bus.mode && (32'(bus.sel) < NUM_CAND)) begin
        result_q <= tally[bus.sel];
      end else begin
        result_q <= '0;
      end
    end
  end

  assign bus.ack          = ack_q;
  assign bus.collision    = coll_q;
  assign bus.busy         = (state == LOCKOUT);
  assign bus.result       = result_q;
  assign bus.result_valid = result_valid_q;

`ifdef TALLY_TOTAL_EN
  localparam int TOT_W = CNT_W + $clog2(NUM_CAND);
  logic [TOT_W-1:0] total_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      total_q <= '0;
    end else if (accept && (total_q != '1)) begin
      total_q <= total_q + 1'b1;
    end
  end

  assign bus.total = total_q;
`endif

endmodule

// File: tb/tb_vote_tally.sv
// tb/tb_vote_tally.sv - directed self-checking bench for vote_tally
// Purpose: reset, single vote, lockout, collision, result gating, saturation, reset mid-lockout.
// Ports: none (top-level bench); TALLY_TOTAL_EN also checks the total output.
module tb_vote_tally;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  int   ack_seen;

  vote_tally_if #(.NUM_CAND(4), .CNT_W(8)) bus ();

  vote_tally #(.NUM_CAND(4), .CNT_W(8), .LOCK_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic vote(input logic [3:0] v);
    bus.vote_pulse = v;
    tick();
    bus.vote_pulse = 4'b0000;
  endtask

  task automatic read_tally(input int idx, input int exp, input string tag);
    bus.mode = 1'b1;
    bus.sel  = 2'(idx);
    tick();
    chk(tag, 32'(bus.result), 32'(exp));
    chk({tag, "_valid"}, 32'(bus.result_valid), 32'd1);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    ack_seen = 0;
    rst = 1'b1;
    bus.mode = 1'b0;
    bus.vote_pulse = 4'b0000;
    bus.sel = 2'd0;
    tick();
    tick();
    rst = 1'b0;

    chk("rst_ack", 32'(bus.ack), 32'd0);
    chk("rst_coll", 32'(bus.collision), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_result", 32'(bus.result), 32'd0);
    chk("rst_rvalid", 32'(bus.result_valid), 32'd0);
`ifdef TALLY_TOTAL_EN
    chk("rst_total", 32'(bus.total), 32'd0);
`endif

    // Single vote on candidate 0: ack with first busy cycle, busy for 4 cycles.
    vote(4'b0001);
    chk("single_ack", 32'(bus.ack), 32'd1);
    chk("single_busy0", 32'(bus.busy), 32'd1);
    for (int k = 1; k < 4; k++) begin
      tick();
      chk($sformatf("single_busy%0d", k), 32'(bus.busy), 32'd1);
      chk($sformatf("single_ack_off%0d", k), 32'(bus.ack), 32'd0);
    end
    tick();
    chk("single_busy_end", 32'(bus.busy), 32'd0);
    read_tally(0, 1, "single_t0");
    bus.mode = 1'b0;
    tick();
    chk("mode0_result", 32'(bus.result), 32'd0);
    chk("mode0_rvalid", 32'(bus.result_valid), 32'd0);

    // Lockout: second pulse 2 cycles after the vote is ignored.
    vote(4'b0100);
    chk("lock_ack1", 32'(bus.ack), 32'd1);
    tick();
    vote(4'b0100);
    chk("lock_ign_ack", 32'(bus.ack), 32'd0);
    chk("lock_ign_coll", 32'(bus.collision), 32'd0);
    chk("lock_ign_busy", 32'(bus.busy), 32'd1);
    tick();
    chk("lock_busy_last", 32'(bus.busy), 32'd1);
    tick();
    chk("lock_busy_fell", 32'(bus.busy), 32'd0);
    vote(4'b0100);
    chk("lock_first_idle_ack", 32'(bus.ack), 32'd1);
    for (int k = 0; k < 4; k++) tick();
    chk("lock_idle_again", 32'(bus.busy), 32'd0);
    read_tally(2, 2, "lock_t2");
    bus.mode = 1'b0;
    tick();

    // Collision.
    vote(4'b0110);
    chk("coll_flag", 32'(bus.collision), 32'd1);
    chk("coll_ack", 32'(bus.ack), 32'd0);
    chk("coll_busy", 32'(bus.busy), 32'd0);
    tick();
    chk("coll_pulse_end", 32'(bus.collision), 32'd0);
    read_tally(0, 1, "coll_t0");
    read_tally(1, 0, "coll_t1");
    read_tally(2, 2, "coll_t2");
    read_tally(3, 0, "coll_t3");

    // Result mode gating: votes ignored while mode=1.
    bus.mode = 1'b1;
    bus.sel = 2'd0;
    vote(4'b0001);
    chk("gate_ack", 32'(bus.ack), 32'd0);
    chk("gate_busy", 32'(bus.busy), 32'd0);
    chk("gate_t0", 32'(bus.result), 32'd1);
    read_tally(0, 1, "gate_t0_after");
    read_tally(1, 0, "gate_sel1");
    bus.mode = 1'b0;
    tick();

    // Saturation: 260 spaced votes on candidate 3.
    for (int n = 0; n < 260; n++) begin
      vote(4'b1000);
      if (bus.ack === 1'b1) ack_seen++;
      for (int k = 0; k < 4; k++) tick();
    end
    chk("sat_acks", 32'(ack_seen), 32'd260);
    read_tally(3, 255, "sat_t3");
`ifdef TALLY_TOTAL_EN
    chk("sat_total", 32'(bus.total), 32'd263);
`endif
    bus.mode = 1'b0;
    tick();

    // Reset mid-lockout.
    vote(4'b0010);
    chk("rml_ack", 32'(bus.ack), 32'd1);
    tick();
    chk("rml_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rml_busy_clr", 32'(bus.busy), 32'd0);
    chk("rml_ack_clr", 32'(bus.ack), 32'd0);
`ifdef TALLY_TOTAL_EN
    chk("rml_total", 32'(bus.total), 32'd0);
`endif
    vote(4'b0001);
    chk("rml_new_ack", 32'(bus.ack), 32'd1);
    chk("rml_new_busy", 32'(bus.busy), 32'd1);
    for (int k = 0; k < 4; k++) tick();
    read_tally(0, 1, "rml_t0");
    read_tally(1, 0, "rml_t1");
    read_tally(2, 0, "rml_t2");
    read_tally(3, 0, "rml_t3");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
